// File: rtl/motor_cmd_scheduler.sv
// Fixed-priority arbiter in front of the single motor command sender, with dedup, min gap and heartbeat.
// Latency: grant/send_start/send_* are registered and appear one cycle after the winning request is sampled.
// Backpressure: requests are held off while busy or while send_ready is low; dropped requests are lost.
module motor_cmd_scheduler #(
  parameter int N_REQ        = 3,
  parameter int SPEED_W      = 9,
  parameter int MIN_GAP_CLKS = 2_500_000,
  parameter int REFRESH_CLKS = 50_000_000,
  parameter int ACK_TIMEOUT  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*SPEED_W-1:0]   req_left,
  input  logic [N_REQ*SPEED_W-1:0]   req_right,
  output logic [N_REQ-1:0]           grant,
  output logic                       send_start,
  output logic [SPEED_W-1:0]         send_left,
  output logic [SPEED_W-1:0]         send_right,
  input  logic                       send_ready,
  output logic                       busy,
  output logic                       err_timeout
);

  // One counter is shared between the ack timeout and the inter-send gap, so size it for the larger.
  localparam int CNT_MAX = (MIN_GAP_CLKS > ACK_TIMEOUT) ? MIN_GAP_CLKS : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int REF_W   = $clog2(REFRESH_CLKS + 1);

  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(MIN_GAP_CLKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [REF_W-1:0]     ref_cnt, ref_nxt;
  logic [SPEED_W-1:0]   last_left, last_left_nxt;
  logic [SPEED_W-1:0]   last_right, last_right_nxt;
  logic                 have_last, have_last_nxt;
  logic [SPEED_W-1:0]   send_left_nxt, send_right_nxt;
  logic [N_REQ-1:0]     grant_nxt;
  logic                 start_nxt;
  logic                 err_nxt;

  logic                 win_vld;
  logic [N_REQ-1:0]     win_oh;
  logic [SPEED_W-1:0]   win_left;
  logic [SPEED_W-1:0]   win_right;
  logic                 win_dup;

  // Pick the lowest-index active requester; scanning from the top lets lower indices overwrite.
  always_comb begin
    win_vld   = 1'b0;
    win_oh    = '0;
    win_left  = '0;
    win_right = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld   = 1'b1;
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_left  = req_left[i*SPEED_W +: SPEED_W];
        win_right = req_right[i*SPEED_W +: SPEED_W];
      end
    end
    win_dup = have_last && (win_left == last_left) && (win_right == last_right);
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ref_nxt        = ref_cnt;
    last_left_nxt  = last_left;
    last_right_nxt = last_right;
    have_last_nxt  = have_last;
    send_left_nxt  = send_left;
    send_right_nxt = send_right;
    grant_nxt      = '0;
    start_nxt      = 1'b0;
    err_nxt        = 1'b0;

    // Heartbeat age, saturating so a long idle period cannot wrap it.
    if (have_last && (ref_cnt != REF_LAST)) begin
      ref_nxt = ref_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (send_ready) begin
          if (win_vld) begin
            grant_nxt = win_oh;
            // A duplicate is acknowledged to the requester but costs no transmission.
            if (!win_dup) begin
              send_left_nxt  = win_left;
              send_right_nxt = win_right;
              last_left_nxt  = win_left;
              last_right_nxt = win_right;
              have_last_nxt  = 1'b1;
              start_nxt      = 1'b1;
              ref_nxt        = '0;
              cnt_nxt        = '0;
              state_nxt      = WAIT_ACK;
            end
          end else if (have_last && (ref_cnt == REF_LAST)) begin
            send_left_nxt  = last_left;
            send_right_nxt = last_right;
            start_nxt      = 1'b1;
            ref_nxt        = '0;
            cnt_nxt        = '0;
            state_nxt      = WAIT_ACK;
          end
        end
      end

      WAIT_ACK: begin
        if (!send_ready) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == ACK_LAST) begin
          // The driver may never have seen this command, so do not let it suppress a resend.
          err_nxt       = 1'b1;
          have_last_nxt = 1'b0;
          cnt_nxt       = '0;
          state_nxt     = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (send_ready) begin
          cnt_nxt   = GAP_LOAD;
          state_nxt = GAP;
        end
      end

      GAP: begin
        if (cnt <= CNT_ONE) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ref_cnt     <= '0;
      last_left   <= '0;
      last_right  <= '0;
      have_last   <= 1'b0;
      send_left   <= '0;
      send_right  <= '0;
      grant       <= '0;
      send_start  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ref_cnt     <= ref_nxt;
      last_left   <= last_left_nxt;
      last_right  <= last_right_nxt;
      have_last   <= have_last_nxt;
      send_left   <= send_left_nxt;
      send_right  <= send_right_nxt;
      grant       <= grant_nxt;
      send_start  <= start_nxt;
      err_timeout <= err_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Bench for motor_cmd_scheduler: scoreboard of expected grant/send events plus per-scenario timing checks.
module tb_motor_cmd_scheduler;

  localparam int N_REQ   = 3;
  localparam int SW      = 9;
  localparam int MIN_GAP = 8;
  localparam int REFRESH = 200;
  localparam int ACK_TO  = 16;

  logic              clk;
  logic              rst;
  logic [N_REQ-1:0]  req;
  logic [N_REQ*SW-1:0] req_left;
  logic [N_REQ*SW-1:0] req_right;
  logic [N_REQ-1:0]  grant;
  logic              send_start;
  logic [SW-1:0]     send_left;
  logic [SW-1:0]     send_right;
  logic              send_ready;
  logic              busy;
  logic              err_timeout;

  motor_cmd_scheduler #(
    .N_REQ(N_REQ), .SPEED_W(SW), .MIN_GAP_CLKS(MIN_GAP),
    .REFRESH_CLKS(REFRESH), .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_left(req_left), .req_right(req_right),
    .grant(grant), .send_start(send_start), .send_left(send_left), .send_right(send_right),
    .send_ready(send_ready), .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [N_REQ-1:0] g;
    logic             s;
    logic [SW-1:0]    l;
    logic [SW-1:0]    r;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_to     = 0;
  int   ready_rise_cyc = 0;
  bit   sender_dead = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Sender model: ready drops 2 cycles after send_start and returns 20 cycles later.
  initial begin
    send_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (send_start === 1'b1 && !sender_dead) begin
        repeat (2) @(posedge clk);
        #1 send_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 send_ready = 1'b1;
        ready_rise_cyc = cyc;
      end
    end
  end

  // Scoreboard: every grant or send_start must match the oldest expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (grant !== '0 || send_start !== 1'b0) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: grant=%b start=%b left=%0d right=%0d at cycle %0d, nothing expected",
                     grant, send_start, send_left, send_right, cyc);
          end else begin
            e = exp_q.pop_front();
            if (grant !== e.g || send_start !== e.s ||
                (e.s && (send_left !== e.l || send_right !== e.r))) begin
              n_fail++;
              $display("FAIL scoreboard: got grant=%b start=%b l=%0d r=%0d, want grant=%b start=%b l=%0d r=%0d (cycle %0d)",
                       grant, send_start, send_left, send_right, e.g, e.s, e.l, e.r, cyc);
            end
          end
        end
        if (err_timeout === 1'b1) n_to++;
      end
    end
  end

  task automatic set_req(input int i, input bit on, input logic [SW-1:0] l, input logic [SW-1:0] r);
    req[i] = on;
    req_left[i*SW +: SW]  = l;
    req_right[i*SW +: SW] = r;
  endtask

  task automatic push_exp(input logic [N_REQ-1:0] g, input logic s, input logic [SW-1:0] l, input logic [SW-1:0] r);
    exp_t e;
    e.g = g; e.s = s; e.l = l; e.r = r;
    exp_q.push_back(e);
  endtask

  // Waits on a DUT condition for at most budget cycles; kind 0=grant[idx] 1=send_start 2=err_timeout 3=busy low 4=ready low.
  task automatic wait_for(input int kind, input int idx, input int budget, output int at, output bit ok);
    ok = 0;
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      case (kind)
        0: ok = (grant[idx] === 1'b1);
        1: ok = (send_start === 1'b1);
        2: ok = (err_timeout === 1'b1);
        3: ok = (busy === 1'b0);
        4: ok = (send_ready === 1'b0);
        default: ok = 0;
      endcase
      if (ok) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '0;
    req_left = '0;
    req_right = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (grant !== '0 || send_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: grant=%b start=%b, want 0/0", grant, send_start);
    end
    n_checks++;
    if (busy !== 1'b0 || err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: busy=%b err=%b, want 0/0", busy, err_timeout);
    end
    n_checks++;
    if (send_left !== '0 || send_right !== '0) begin
      n_fail++; $display("FAIL reset_speeds: l=%0d r=%0d, want 0/0", send_left, send_right);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_issue();
    int c0, at;
    bit ok;
    c0 = cyc;
    set_req(2, 1, 9'd100, 9'd100);
    push_exp(3'b100, 1'b1, 9'd100, 9'd100);
    wait_for(0, 2, 10, at, ok);
    n_checks++;
    if (!ok || at != c0 + 1) begin
      n_fail++; $display("FAIL issue_latency: grant at cycle %0d, want %0d", at, c0 + 1);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL issue_busy: busy=%b, want 1", busy);
    end
    set_req(2, 0, 9'd0, 9'd0);
    wait_for(3, 0, 100, at, ok);
    n_checks++;
    if (!ok || (at - ready_rise_cyc) < MIN_GAP || (at - ready_rise_cyc) > MIN_GAP + 1) begin
      n_fail++; $display("FAIL issue_gap: busy fell %0d cycles after ready, want %0d..%0d",
                         at - ready_rise_cyc, MIN_GAP, MIN_GAP + 1);
    end
    n_checks++;
    if (send_left !== 9'd100 || send_right !== 9'd100) begin
      n_fail++; $display("FAIL issue_hold: l=%0d r=%0d, want 100/100", send_left, send_right);
    end
  endtask

  task automatic test_duplicate();
    int c0, at;
    bit ok;
    c0 = cyc;
    set_req(2, 1, 9'd100, 9'd100);
    push_exp(3'b100, 1'b0, 9'd0, 9'd0);
    wait_for(0, 2, 10, at, ok);
    n_checks++;
    if (!ok || at != c0 + 1) begin
      n_fail++; $display("FAIL dup_latency: grant at cycle %0d, want %0d", at, c0 + 1);
    end
    n_checks++;
    if (busy !== 1'b0 || send_start !== 1'b0) begin
      n_fail++; $display("FAIL dup_nosend: busy=%b start=%b, want 0/0", busy, send_start);
    end
    set_req(2, 0, 9'd0, 9'd0);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      n_fail++; $display("FAIL dup_after: busy=%b grant=%b, want 0/000", busy, grant);
    end
  endtask

  int hb_ref;

  task automatic test_priority();
    int c0, at, g1;
    bit ok;
    c0 = cyc;
    set_req(0, 1, 9'd0, 9'd0);
    set_req(1, 1, 9'd50, -9'sd20);
    push_exp(3'b001, 1'b1, 9'd0, 9'd0);
    push_exp(3'b010, 1'b1, 9'd50, -9'sd20);
    wait_for(0, 0, 10, at, ok);
    n_checks++;
    if (!ok || at != c0 + 1) begin
      n_fail++; $display("FAIL prio_first: grant[0] at cycle %0d, want %0d", at, c0 + 1);
    end
    set_req(0, 0, 9'd0, 9'd0);
    wait_for(0, 1, 200, g1, ok);
    n_checks++;
    if (!ok || (g1 - ready_rise_cyc) < MIN_GAP + 1) begin
      n_fail++; $display("FAIL prio_gap: grant[1] %0d cycles after ready, want >= %0d",
                         g1 - ready_rise_cyc, MIN_GAP + 1);
    end
    hb_ref = g1;
    set_req(1, 0, 9'd0, 9'd0);
  endtask

  task automatic test_heartbeat();
    int at;
    bit ok;
    push_exp(3'b000, 1'b1, 9'd50, -9'sd20);
    wait_for(1, 0, 300, at, ok);
    n_checks++;
    if (!ok || at - hb_ref != REFRESH) begin
      n_fail++; $display("FAIL heartbeat_period: %0d cycles after last start, want %0d", at - hb_ref, REFRESH);
    end
    n_checks++;
    if (grant !== '0) begin
      n_fail++; $display("FAIL heartbeat_grant: grant=%b, want 000", grant);
    end
    wait_for(3, 0, 100, at, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL heartbeat_idle: busy=%b after 100 cycles, want 0", busy);
    end
  endtask

  task automatic test_timeout();
    int c0, s, t;
    bit ok;
    sender_dead = 1;
    c0 = cyc;
    set_req(2, 1, 9'd30, 9'd30);
    push_exp(3'b100, 1'b1, 9'd30, 9'd30);
    wait_for(0, 2, 10, s, ok);
    n_checks++;
    if (!ok || s != c0 + 1) begin
      n_fail++; $display("FAIL timeout_issue: grant at cycle %0d, want %0d", s, c0 + 1);
    end
    set_req(2, 0, 9'd0, 9'd0);
    wait_for(2, 0, 40, t, ok);
    n_checks++;
    if (!ok || t - s != ACK_TO) begin
      n_fail++; $display("FAIL timeout_delay: err %0d cycles after start, want %0d", t - s, ACK_TO);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_idle: busy=%b, want 0", busy);
    end
    sender_dead = 0;
    set_req(2, 1, 9'd30, 9'd30);
    push_exp(3'b100, 1'b1, 9'd30, 9'd30);
    wait_for(0, 2, 10, s, ok);
    n_checks++;
    if (!ok || send_start !== 1'b1) begin
      n_fail++; $display("FAIL timeout_resend: start=%b, want 1", send_start);
    end
    set_req(2, 0, 9'd0, 9'd0);
    wait_for(3, 0, 100, t, ok);
  endtask

  task automatic test_reset_mid();
    int at;
    bit ok;
    set_req(1, 1, 9'd70, 9'd70);
    push_exp(3'b010, 1'b1, 9'd70, 9'd70);
    wait_for(0, 1, 10, at, ok);
    set_req(1, 0, 9'd0, 9'd0);
    wait_for(4, 0, 10, at, ok);
    repeat (2) @(negedge clk);
    n_checks++;
    if (!ok || busy !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: busy=%b ready_low_seen=%0d, want busy 1", busy, ok);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant !== '0 || send_start !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0 ||
        send_left !== '0 || send_right !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: grant=%b start=%b busy=%b err=%b l=%0d r=%0d, want all 0",
                         grant, send_start, busy, err_timeout, send_left, send_right);
    end
    rst = 1'b1;
    set_req(1, 1, 9'd70, 9'd70);
    push_exp(3'b010, 1'b1, 9'd70, 9'd70);
    wait_for(0, 1, 100, at, ok);
    n_checks++;
    if (!ok || send_start !== 1'b1) begin
      n_fail++; $display("FAIL midreset_resend: grant_seen=%0d start=%b, want 1/1", ok, send_start);
    end
    set_req(1, 0, 9'd0, 9'd0);
    wait_for(3, 0, 100, at, ok);
  endtask

  initial begin
    test_reset();
    test_issue();
    test_duplicate();
    test_priority();
    test_heartbeat();
    test_timeout();
    test_reset_mid();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d events never seen, want 0", exp_q.size());
    end
    n_checks++;
    if (n_to != 1) begin
      n_fail++; $display("FAIL timeout_count: %0d err_timeout pulses, want 1", n_to);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
